axil_csr_bridge: RTL

AXIL_CSR_BRIDGE -- requirements
Module: axil_csr_bridge

---
 rtl/axil_csr_pkg.sv | 17 +
 rtl/axil_csr_timeout.sv | 40 ++++
 rtl/axil_csr_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/axil_csr_pkg.sv
// Shared types and constants for the AXI4-Lite to CSR bridge.
package axil_csr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Counter width for the CSR ack timeout; TIMEOUT must fit in it.
  localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/axil_csr_timeout.sv
// Ack-wait counter: cleared on request start, counts cycles without ack,
// flags expiry on the TIMEOUT-th cycle of an unacknowledged request.
module axil_csr_timeout
  import axil_csr_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic expire
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && !ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // An ack in the final cycle still wins over expiry.
  assign expire = run && !ack && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave that turns each write or read into one req/ack CSR access,
// with one-entry AW/W/AR buffers, fair write/read arbitration and a timeout.
module axil_csr_bridge
  import axil_csr_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [31:0]       s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic              csr_req,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [31:0]       csr_wdata,
  output logic [3:0]        csr_wstrb,
  input  logic              csr_ack,
  input  logic [31:0]       csr_rdata,
  output logic              err,
  input  logic              err_clr
);

  // Handshakes: a channel transfers on a cycle where valid && ready; the
  // master holds valid/payload until then, the bridge never withdraws valid.
  state_e state_q, state_d;

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              ar_full_q, ar_full_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              prefer_wr_q, prefer_wr_d;
  logic              csr_we_q, csr_we_d;
  logic [ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic [31:0]       csr_wdata_q, csr_wdata_d;
  logic [3:0]        csr_wstrb_q, csr_wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic to_start, to_run, expire;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[31:ADDR_W+2], s_axi_awaddr[1:0],
                           s_axi_araddr[31:ADDR_W+2], s_axi_araddr[1:0]};

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Count a beat being captured this cycle so csr_req rises the next cycle.
  assign wr_elig  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign rd_elig  = ar_full_q || ar_hs;
  assign grant_wr = (state_q == IDLE) && wr_elig && (!rd_elig || prefer_wr_q);
  assign grant_rd = (state_q == IDLE) && rd_elig && !grant_wr;

  assign to_start = grant_wr || grant_rd;
  assign to_run   = (state_q == WR_REQ) || (state_q == RD_REQ);

  axil_csr_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .start (to_start),
    .run   (to_run),
    .ack   (csr_ack),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_wr)      state_d = WR_REQ;
        else if (grant_rd) state_d = RD_REQ;
      end
      WR_REQ:  if (csr_ack || expire) state_d = WR_RESP;
      RD_REQ:  if (csr_ack || expire) state_d = RD_RESP;
      WR_RESP: if (s_axi_bready) state_d = IDLE;
      RD_RESP: if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    csr_req       = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_awready = !aw_full_q;
        s_axi_wready  = !w_full_q;
        s_axi_arready = !ar_full_q;
      end
      WR_REQ, RD_REQ: csr_req = 1'b1;
      WR_RESP:        s_axi_bvalid = 1'b1;
      RD_RESP:        s_axi_rvalid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    ar_full_d   = ar_full_q;
    ar_addr_d   = ar_addr_q;
    prefer_wr_d = prefer_wr_q;
    csr_we_d    = csr_we_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_wstrb_d = csr_wstrb_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi_awaddr[ADDR_W+1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axi_araddr[ADDR_W+1:2];
    end

    // Only a contested cycle moves priority to the loser.
    if (state_q == IDLE && wr_elig && rd_elig) prefer_wr_d = grant_rd;

    if (grant_wr) begin
      csr_we_d    = 1'b1;
      csr_addr_d  = aw_full_q ? aw_addr_q : s_axi_awaddr[ADDR_W+1:2];
      csr_wdata_d = w_full_q ? w_data_q : s_axi_wdata;
      csr_wstrb_d = w_full_q ? w_strb_q : s_axi_wstrb;
    end else if (grant_rd) begin
      csr_we_d    = 1'b0;
      csr_addr_d  = ar_full_q ? ar_addr_q : s_axi_araddr[ADDR_W+1:2];
      csr_wdata_d = '0;
      csr_wstrb_d = 4'h0;
    end

    if (state_q == RD_REQ && csr_ack) rdata_d = csr_rdata;
    if (state_q == RD_REQ && expire)  rdata_d = ERR_RDATA;

    if (state_q == WR_RESP && s_axi_bready) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (state_q == RD_RESP && s_axi_rready) ar_full_d = 1'b0;

    if (expire)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= 4'h0;
      ar_full_q   <= 1'b0;
      ar_addr_q   <= '0;
      prefer_wr_q <= 1'b1;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wstrb_q <= 4'h0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      ar_full_q   <= ar_full_d;
      ar_addr_q   <= ar_addr_d;
      prefer_wr_q <= prefer_wr_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_wstrb_q <= csr_wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign csr_we      = csr_we_q;
  assign csr_addr    = csr_addr_q;
  assign csr_wdata   = csr_wdata_q;
  assign csr_wstrb   = csr_wstrb_q;
  assign s_axi_rdata = rdata_q;
  assign err         = err_q;

endmodule
